// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Optional statistics counters are enabled with FIFO_WR_ARBITER_STATS_EN.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int STAT_W = 16;

    // Index width for n items; never below 1 so a two-entry index still has a bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set request after i_last_grant, with wrap.
// Shared with the future read-side scheduler.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any_req
);

    always_comb begin
        o_winner  = '0;
        o_any_req = |i_req;
        // Scan farthest-first so the nearest requester after i_last_grant overwrites last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req[(int'(i_last_grant) + k) % NUM_REQ]) begin
                o_winner = ID_W'((int'(i_last_grant) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARBITER_STATS_EN to add per-requester accepted-word counters.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wt_en,
    output logic [DATA_W-1:0]             fifo_data_in,
    input  logic                          fifo_full,
    output logic [id_w(NUM_REQ)-1:0]      grant_id,
    output logic                          busy
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [NUM_REQ*STAT_W-1:0]     stat_words
`endif
);

    localparam int ID_W  = id_w(NUM_REQ);
    localparam int CNT_W = id_w(MAX_BURST + 1);

    // Handshake: a word moves on a cycle where req_valid[i] & req_ready[i]; ready is
    // only ever offered to the granted requester and never while the FIFO is full.
    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    r_last_grant;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_beat_inc;
    logic [ID_W-1:0]    w_winner;
    logic               w_any_req;
    logic               w_xfer;
    logic               w_burst_end;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any_req    (w_any_req)
    );

    assign w_beat_inc = r_beat_cnt + 1'b1;

    always_comb begin
        req_ready    = '0;
        fifo_wt_en   = 1'b0;
        fifo_data_in = '0;
        w_xfer       = 1'b0;
        w_burst_end  = 1'b0;
        w_state_nxt  = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                req_ready[r_grant_id] = ~fifo_full;
                fifo_wt_en            = req_valid[r_grant_id] & ~fifo_full;
                w_xfer                = fifo_wt_en;
                if (fifo_wt_en) begin
                    fifo_data_in = req_data[r_grant_id*DATA_W +: DATA_W];
                end
                // A full FIFO freezes the burst: no transfer, no withdrawal, no last.
                if (w_xfer) begin
                    w_burst_end = req_last[r_grant_id] ||
                                  (w_beat_inc == CNT_W'(MAX_BURST));
                end else if (!fifo_full && !req_valid[r_grant_id]) begin
                    w_burst_end = 1'b1;
                end
                if (w_burst_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                if (w_any_req) begin
                    r_grant_id <= w_winner;
                    r_beat_cnt <= '0;
                end
            end else begin
                if (w_xfer) begin
                    r_beat_cnt <= w_beat_inc;
                end
                if (w_burst_end) begin
                    r_last_grant <= r_grant_id;
                end
            end
        end
    end

    assign grant_id = r_grant_id;
    assign busy     = (r_state == GRANT);

`ifdef FIFO_WR_ARBITER_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        logic [STAT_W-1:0] r_words;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_words <= '0;
            end else if (stat_clr) begin
                r_words <= '0;
            end else if (w_xfer && (r_grant_id == ID_W'(gi)) && (r_words != '1)) begin
                r_words <= r_words + 1'b1;
            end
        end

        assign stat_words[gi*STAT_W +: STAT_W] = r_words;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer and FIFO models plus a write scoreboard.
// Define FIFO_WR_ARBITER_STATS_EN to also exercise the statistics counters.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_wt_en;
    logic [3:0]  fifo_data_in;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic        stat_clr;
    logic [63:0] stat_words;
`endif

    int checks   = 0;
    int failures = 0;

    // Producer model: per-requester word memory, head advanced on handshake.
    logic [4:0] pmem [4][64];
    int         phead [4] = '{0, 0, 0, 0};
    int         ptail [4] = '{0, 0, 0, 0};

    // FIFO occupancy model (16 entries).
    int   fifo_cnt = 0;
    logic drain;
    logic fifo_rd;
    logic fifo_set;
    int   fifo_set_val;

    logic [5:0] exp_q[$];

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (4),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wt_en   (fifo_wt_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_words   (stat_words)
`endif
    );

    // Clock and reset-independent models
    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < 4; i++) begin
            if (phead[i] != ptail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*4 +: 4] = pmem[i][phead[i]][3:0];
                req_last[i]        = pmem[i][phead[i]][4];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) phead[i] <= phead[i] + 1;
        end
    end

    assign fifo_full = (fifo_cnt >= 16);

    always @(posedge clk) begin
        if (fifo_set) begin
            fifo_cnt <= fifo_set_val;
        end else begin
            fifo_cnt <= fifo_cnt + (fifo_wt_en ? 1 : 0)
                        - (((fifo_rd || drain) && fifo_cnt > 0) ? 1 : 0);
        end
    end

    // Scoreboard monitor: every FIFO write must match the head of exp_q.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && fifo_wt_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_write actual id=%0d data=%0h required=no write",
                             grant_id, fifo_data_in);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant_id, fifo_data_in} !== e) begin
                        failures++;
                        $display("FAIL sb_word actual id=%0d data=%0h required id=%0d data=%0h",
                                 grant_id, fifo_data_in, e[5:4], e[3:0]);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int id, input logic [3:0] d, input logic last);
        pmem[id][ptail[id]] = {last, d};
        ptail[id] = ptail[id] + 1;
    endtask

    task automatic expect_word(input logic [1:0] id, input logic [3:0] d);
        exp_q.push_back({id, d});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) step();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] hist;
        rst          = 1'b0;
        drain        = 1'b1;
        fifo_rd      = 1'b0;
        fifo_set     = 1'b0;
        fifo_set_val = 0;
`ifdef FIFO_WR_ARBITER_STATS_EN
        stat_clr     = 1'b0;
`endif
        step();
        step();

        // Test 1: reset values, then req0 and req2 bursts of 3.
        load(0, 4'h1, 1'b0); load(0, 4'h2, 1'b0); load(0, 4'h3, 1'b1);
        load(2, 4'h4, 1'b0); load(2, 4'h5, 1'b0); load(2, 4'h6, 1'b1);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_wt_en", fifo_wt_en, 1'b0);
        chk("rst_data", fifo_data_in, 4'h0);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        expect_word(0, 4'h1); expect_word(0, 4'h2); expect_word(0, 4'h3);
        expect_word(2, 4'h4); expect_word(2, 4'h5); expect_word(2, 4'h6);
        rst = 1'b1;
        for (int w = 0; w < 10; w++) begin
            hist[w] = fifo_wt_en;
            step();
        end
        chk("t1_wt_en_pattern", hist, 10'b0011101110);
        wait_drain("t1_drain");

        // Test 2: four requesters, no last, bursts capped at 4; order 0,1,2,3,0.
        rst = 1'b0;
        step();
        for (int k = 0; k < 8; k++) load(0, 4'(k + 1), 1'b0);
        for (int k = 0; k < 4; k++) load(1, 4'(k + 9), 1'b0);
        for (int k = 0; k < 4; k++) load(2, 4'(k + 13), 1'b0);
        for (int k = 0; k < 4; k++) load(3, 4'(k + 2), 1'b0);
        for (int k = 0; k < 4; k++) expect_word(0, 4'(k + 1));
        for (int k = 0; k < 4; k++) expect_word(1, 4'(k + 9));
        for (int k = 0; k < 4; k++) expect_word(2, 4'(k + 13));
        for (int k = 0; k < 4; k++) expect_word(3, 4'(k + 2));
        for (int k = 4; k < 8; k++) expect_word(0, 4'(k + 1));
        rst = 1'b1;
        wait_drain("t2_drain");
        repeat (4) step();

        // Test 3: FIFO at 15 entries; req1 stalls on full, last word held while full.
        drain        = 1'b0;
        fifo_set     = 1'b1;
        fifo_set_val = 15;
        step();
        fifo_set = 1'b0;
        load(1, 4'h3, 1'b0); load(1, 4'h4, 1'b0); load(1, 4'h5, 1'b1);
        expect_word(1, 4'h3); expect_word(1, 4'h4); expect_word(1, 4'h5);
        step();
        chk("t3_first_word_wt", fifo_wt_en, 1'b1);
        step();
        chk("t3_full_ready", req_ready, 4'b0000);
        chk("t3_full_wt", fifo_wt_en, 1'b0);
        chk("t3_full_busy", busy, 1'b1);
        chk("t3_full_grant", grant_id, 2'd1);
        step();
        chk("t3_full_wt_hold", fifo_wt_en, 1'b0);
        fifo_rd = 1'b1;
        step();
        fifo_rd = 1'b0;
        chk("t3_second_word_wt", fifo_wt_en, 1'b1);
        step();
        chk("t3_last_full_busy", busy, 1'b1);
        chk("t3_last_full_ready", req_ready, 4'b0000);
        chk("t3_last_full_wt", fifo_wt_en, 1'b0);
        fifo_rd = 1'b1;
        step();
        fifo_rd = 1'b0;
        chk("t3_last_word_wt", fifo_wt_en, 1'b1);
        step();
        chk("t3_idle_after_last", busy, 1'b0);
        drain = 1'b1;
        wait_drain("t3_drain");
        repeat (20) step();

        // Test 4: req3 withdraws after one word, pending req0 served next.
        load(3, 4'h9, 1'b0);
        load(0, 4'h1, 1'b0); load(0, 4'h2, 1'b1);
        expect_word(3, 4'h9); expect_word(0, 4'h1); expect_word(0, 4'h2);
        step();
        chk("t4_grant3", grant_id, 2'd3);
        chk("t4_word_wt", fifo_wt_en, 1'b1);
        step();
        chk("t4_withdraw_busy", busy, 1'b1);
        chk("t4_withdraw_wt", fifo_wt_en, 1'b0);
        step();
        chk("t4_idle", busy, 1'b0);
        step();
        chk("t4_busy_req0", busy, 1'b1);
        chk("t4_grant0", grant_id, 2'd0);
        wait_drain("t4_drain");
        repeat (4) step();

        // Test 5: reset after two beats of a req2 burst.
        for (int k = 0; k < 4; k++) load(2, 4'(k + 10), 1'b0);
        expect_word(2, 4'hA); expect_word(2, 4'hB);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_rst_ready", req_ready, 4'b0000);
        chk("t5_rst_wt", fifo_wt_en, 1'b0);
        chk("t5_rst_data", fifo_data_in, 4'h0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_grant", grant_id, 2'd0);
        chk("t5_words_before_rst", exp_q.size(), 0);
        ptail[2] = phead[2];
        step();
        rst = 1'b1;
        load(0, 4'h5, 1'b1);
        load(2, 4'h6, 1'b1);
        expect_word(0, 4'h5); expect_word(2, 4'h6);
        step();
        chk("t5_after_rst_grant", grant_id, 2'd0);
        chk("t5_after_rst_busy", busy, 1'b1);
        wait_drain("t5_drain");
        repeat (4) step();

`ifdef FIFO_WR_ARBITER_STATS_EN
        // Counters restart at reset: one word each from req0 and req2 since then.
        chk("stat_req0", stat_words[15:0], 16'd1);
        chk("stat_req1", stat_words[31:16], 16'd0);
        chk("stat_req2", stat_words[47:32], 16'd1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("stat_clear", stat_words, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
